// File: rtl/lemming_bridge_arbiter.sv
// Round-robin arbiter granting one walker at a time onto the shared bridge tile.
// Define LEMMING_BRIDGE_TIMEOUT_EN to force-release crossings after CROSS_CYCLES.
module lemming_bridge_arbiter #(
  parameter int N            = 4,
  parameter int CROSS_CYCLES = 8
) (
  input  logic         clk,
  input  logic         areset,
  input  logic [N-1:0] req,
  input  logic [N-1:0] done,
  output logic [N-1:0] grant,
  output logic         busy,
  output logic [2:0]   owner,
  output logic         timeout
);

  typedef enum logic [1:0] {IDLE, CROSS, CLEAR} state_t;

  localparam logic [3:0] NW = 4'(N);

  state_t       state_q, state_d;
  logic [N-1:0] grant_q, grant_d;
  logic         busy_q, busy_d;
  logic [2:0]   owner_q, owner_d;
  logic [2:0]   ptr_q, ptr_d;

  logic [2:0]   pick;
  logic [N-1:0] pick_oh;
  logic [N-1:0] sel;
  logic [3:0]   idx;
  logic         found;
  logic [3:0]   nxt;
  logic         own_done, own_req, expired, rel;

  assign own_done = |(done & grant_q);
  assign own_req  = |(req & grant_q);

`ifdef LEMMING_BRIDGE_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       tmo_q, tmo_d;

  assign expired = (cnt_q == 8'd0);
  assign timeout = tmo_q;

  always_comb begin
    cnt_d = cnt_q;
    tmo_d = 1'b0;
    if (state_q == IDLE && found) begin
      cnt_d = 8'(CROSS_CYCLES - 1);
    end else if (state_q == CROSS) begin
      if (rel) tmo_d = !own_done && own_req;
      else if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
`else
  assign expired = 1'b0;
  assign timeout = 1'b0;
`endif

  assign rel = (state_q == CROSS) &&
               (own_done || !own_req || expired);

  // First requester at or above ptr, wrapping.
  always_comb begin
    pick    = '0;
    pick_oh = '0;
    found   = 1'b0;
    idx     = '0;
    sel     = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr_q} + 4'(i);
      if (idx >= NW) idx = idx - NW;
      sel = N'(1) << idx;
      if (!found && |(req & sel)) begin
        found   = 1'b1;
        pick    = idx[2:0];
        pick_oh = sel;
      end
    end
  end

  always_comb begin
    nxt = {1'b0, owner_q} + 4'd1;
    if (nxt == NW) nxt = '0;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick_oh;
          owner_d = pick;
          busy_d  = 1'b1;
          state_d = CROSS;
        end
      end
      CROSS: begin
        if (rel) begin
          grant_d = '0;
          ptr_d   = nxt[2:0];
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_lemming_bridge_arbiter.sv
// Directed bench for lemming_bridge_arbiter (N=4, CROSS_CYCLES=8).
// Timeout expectations follow LEMMING_BRIDGE_TIMEOUT_EN.
module tb_lemming_bridge_arbiter;

  logic       clk = 1'b0;
  logic       areset = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] done = '0;
  logic [3:0] grant;
  logic       busy;
  logic [2:0] owner;
  logic       timeout;

  int total = 0;
  int bad = 0;

  lemming_bridge_arbiter #(.N(4), .CROSS_CYCLES(8)) dut (
    .clk(clk),
    .areset(areset),
    .req(req),
    .done(done),
    .grant(grant),
    .busy(busy),
    .owner(owner),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    total++;
    if (!$onehot0(grant)) begin
      bad++;
      $display("FAIL onehot0 grant=%b", grant);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b0;
    req = '0;
    done = '0;
    tick();
    tick();
    areset = 1'b1;
  endtask

  task automatic test_reset();
    areset = 1'b0;
    req = 4'b1111;
    tick();
    tick();
    total++;
    if (grant !== 4'b0000 || busy !== 1'b0 ||
        owner !== 3'd0 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL reset_state g=%b b=%b o=%0d t=%b want 0000/0/0/0",
               grant, busy, owner, timeout);
    end
    areset = 1'b1;
    tick();
    total++;
    if (grant !== 4'b0001 || busy !== 1'b1 || owner !== 3'd0) begin
      bad++;
      $display("FAIL reset_first_grant g=%b b=%b o=%0d want 0001/1/0",
               grant, busy, owner);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] eg [4];
    int eo [4];
    eg = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    eo = '{0, 1, 3, 0};
    do_reset();
    req = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (grant !== eg[k] || owner !== 3'(eo[k])) begin
        bad++;
        $display("FAIL rot_grant%0d g=%b o=%0d want %b/%0d",
                 k, grant, owner, eg[k], eo[k]);
      end
      tick();
      tick();
      total++;
      if (grant !== eg[k]) begin
        bad++;
        $display("FAIL rot_hold%0d g=%b want %b", k, grant, eg[k]);
      end
      done = eg[k];
      tick();
      done = '0;
      total++;
      if (grant !== 4'b0000 || busy !== 1'b1) begin
        bad++;
        $display("FAIL rot_clear%0d g=%b b=%b want 0000/1", k, grant, busy);
      end
      tick();
      total++;
      if (grant !== 4'b0000 || busy !== 1'b0) begin
        bad++;
        $display("FAIL rot_gap%0d g=%b b=%b want 0000/0", k, grant, busy);
      end
    end
  endtask

  task automatic test_abandon();
    do_reset();
    req = 4'b0100;
    tick();
    total++;
    if (grant !== 4'b0100 || owner !== 3'd2) begin
      bad++;
      $display("FAIL abn_grant g=%b o=%0d want 0100/2", grant, owner);
    end
    tick();
    req = 4'b0001;
    tick();
    total++;
    if (grant !== 4'b0000 || busy !== 1'b1 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL abn_release g=%b b=%b t=%b want 0000/1/0",
               grant, busy, timeout);
    end
    tick();
    total++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abn_gap g=%b b=%b want 0000/0", grant, busy);
    end
    tick();
    total++;
    if (grant !== 4'b0001 || owner !== 3'd0 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL abn_next g=%b o=%0d t=%b want 0001/0/0",
               grant, owner, timeout);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0100;
    tick();
    for (int i = 1; i < 8; i++) begin
      tick();
      total++;
      if (grant !== 4'b0100 || timeout !== 1'b0) begin
        bad++;
        $display("FAIL tmo_hold%0d g=%b t=%b want 0100/0", i, grant, timeout);
      end
    end
    tick();
`ifdef LEMMING_BRIDGE_TIMEOUT_EN
    total++;
    if (grant !== 4'b0000 || timeout !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL tmo_pulse g=%b t=%b b=%b want 0000/1/1",
               grant, timeout, busy);
    end
    tick();
    total++;
    if (grant !== 4'b0000 || timeout !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL tmo_after g=%b t=%b b=%b want 0000/0/0",
               grant, timeout, busy);
    end
    tick();
    total++;
    if (grant !== 4'b0100 || owner !== 3'd2) begin
      bad++;
      $display("FAIL tmo_regrant g=%b o=%0d want 0100/2", grant, owner);
    end
`else
    repeat (6) tick();
    total++;
    if (grant !== 4'b0100 || timeout !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL tmo_holds g=%b t=%b b=%b want 0100/0/1",
               grant, timeout, busy);
    end
`endif
  endtask

  task automatic test_collision();
    do_reset();
    req = 4'b0100;
    tick();
    for (int i = 1; i < 8; i++) begin
      done = (i == 2) ? 4'b1011 : 4'b0000;
      tick();
      total++;
      if (grant !== 4'b0100) begin
        bad++;
        $display("FAIL col_hold%0d g=%b want 0100", i, grant);
      end
    end
    done = 4'b0100;
    tick();
    done = '0;
    total++;
    if (grant !== 4'b0000 || timeout !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL col_release g=%b t=%b b=%b want 0000/0/1",
               grant, timeout, busy);
    end
    tick();
    total++;
    if (timeout !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL col_after t=%b b=%b want 0/0", timeout, busy);
    end
  endtask

  task automatic test_midop_reset();
    do_reset();
    req = 4'b0001;
    tick();
    done = 4'b0001;
    tick();
    done = '0;
    req = 4'b0011;
    tick();
    tick();
    total++;
    if (grant !== 4'b0010 || owner !== 3'd1) begin
      bad++;
      $display("FAIL mid_grant g=%b o=%0d want 0010/1", grant, owner);
    end
    tick();
    tick();
    areset = 1'b0;
    #1;
    total++;
    if (grant !== 4'b0000 || busy !== 1'b0 || owner !== 3'd0) begin
      bad++;
      $display("FAIL mid_async g=%b b=%b o=%0d want 0000/0/0",
               grant, busy, owner);
    end
    #1;
    areset = 1'b1;
    tick();
    total++;
    if (grant !== 4'b0001 || owner !== 3'd0) begin
      bad++;
      $display("FAIL mid_restart g=%b o=%0d want 0001/0", grant, owner);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_abandon();
    test_timeout();
    test_collision();
    test_midop_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
